pc_redirect_ctrl: RTL and testbench

Fetch-stage program-counter controller for the five-stage pipeline. It owns the PC register and selects each cycle between sequential fetch, a jump redirect decoded in ID (pseudo-direct target), and a taken-branch redirect resolved in EX. It also generates the IF/ID and ID/EX flush pulses. A redirect that cannot be applied immediately, because of a hazard stall or a not-ready instruction memory, is held in a one-entry pending register until it can be applied.

---
 rtl/pc_redirect_ctrl.sv | 101 ++++++++++
 tb/tb_pc_redirect_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch-stage PC register with jump/branch redirect and one-entry pending hold
module pc_redirect_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             id_valid,
  input  logic             id_is_jump,
  input  logic [31:0]      id_pc_plus4,
  input  logic [25:0]      id_jumpinstr,
  input  logic             ex_branch_taken,
  input  logic [31:0]      ex_branch_target,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic [CNT_W-1:0] jump_count,
  output logic [CNT_W-1:0] branch_count
);

  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t      state, state_n;
  logic [31:0] pending_target, pending_n;
  logic [31:0] pc_n;
  logic        fetch_ok;
  logic        advance;
  logic        br_acc, jmp_acc, redirect;
  logic [31:0] jump_target, redirect_target;
  logic        unused_pc_low;

  // Only the top nibble of PC+4 participates in the pseudo-direct target.
  assign unused_pc_low = ^id_pc_plus4[27:0];

  // Redirect acceptance: a taken branch always wins; a jump waits out stalls and yields to a branch.
  always_comb begin
    advance         = !stall && imem_ready;
    br_acc          = ex_branch_taken && !rst;
    jmp_acc         = id_valid && id_is_jump && !stall && !ex_branch_taken && !rst;
    redirect        = br_acc || jmp_acc;
    jump_target     = {id_pc_plus4[31:28], id_jumpinstr, 2'b00};
    redirect_target = br_acc ? ex_branch_target : jump_target;
  end

  // State, PC, pending target and counters; reset overrides everything including a pending redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= RUN;
      pc             <= RESET_PC;
      pending_target <= 32'h0;
      fetch_ok       <= 1'b0;
      jump_count     <= '0;
      branch_count   <= '0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      pending_target <= pending_n;
      fetch_ok       <= 1'b1;
      if (jmp_acc && (jump_count != {CNT_W{1'b1}}))
        jump_count <= jump_count + CNT_ONE;
      if (br_acc && (branch_count != {CNT_W{1'b1}}))
        branch_count <= branch_count + CNT_ONE;
    end
  end

  // Next-PC priority: new redirect, then pending redirect, then sequential fetch.
  always_comb begin
    state_n   = state;
    pc_n      = pc;
    pending_n = pending_target;
    if (redirect) begin
      if (advance) begin
        pc_n    = redirect_target;
        state_n = RUN;
      end else begin
        pending_n = redirect_target;
        state_n   = HOLD;
      end
    end else if (state == HOLD) begin
      if (advance) begin
        pc_n    = pending_target;
        state_n = RUN;
      end
    end else if (advance) begin
      pc_n = pc + 32'd4;
    end
  end

  // Outputs: flushes are same-cycle pulses of the accepted redirect; fetch is invalid while holding.
  always_comb begin
    flush_ifid  = redirect;
    flush_idex  = br_acc;
    fetch_valid = fetch_ok && (state == RUN);
  end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed self-checking bench for pc_redirect_ctrl
module tb_pc_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall, imem_ready, id_valid, id_is_jump, ex_branch_taken;
  logic [31:0] id_pc_plus4, ex_branch_target;
  logic [25:0] id_jumpinstr;
  logic [31:0] pc;
  logic        fetch_valid, flush_ifid, flush_idex;
  logic [15:0] jump_count, branch_count;

  logic [31:0] s_pc;
  logic        s_fetch_valid, s_flush_ifid, s_flush_idex;
  logic [1:0]  s_jump_count, s_branch_count;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .id_valid(id_valid), .id_is_jump(id_is_jump), .id_pc_plus4(id_pc_plus4),
    .id_jumpinstr(id_jumpinstr), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .pc(pc), .fetch_valid(fetch_valid),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .jump_count(jump_count), .branch_count(branch_count)
  );

  // Narrow-counter instance so saturation is reachable in a few jumps.
  pc_redirect_ctrl #(.RESET_PC(32'h0000_0000), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .stall(stall), .imem_ready(imem_ready),
    .id_valid(id_valid), .id_is_jump(id_is_jump), .id_pc_plus4(id_pc_plus4),
    .id_jumpinstr(id_jumpinstr), .ex_branch_taken(ex_branch_taken),
    .ex_branch_target(ex_branch_target), .pc(s_pc), .fetch_valid(s_fetch_valid),
    .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
    .jump_count(s_jump_count), .branch_count(s_branch_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 1'b0; imem_ready = 1'b1; id_valid = 1'b0; id_is_jump = 1'b0;
    id_pc_plus4 = 32'h0; id_jumpinstr = 26'h0;
    ex_branch_taken = 1'b0; ex_branch_target = 32'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0800;
    id_valid = 1'b1; id_is_jump = 1'b1;
    step();
    n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL reset_flush_ifid got %0b want 0", flush_ifid); end
    n_checks++; if (flush_idex !== 1'b0) begin n_fail++; $display("FAIL reset_flush_idex got %0b want 0", flush_idex); end
    n_checks++; if (pc !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 00000000", pc); end
    n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL reset_fetch_valid got %0b want 0", fetch_valid); end
    n_checks++; if (jump_count !== 16'h0 || branch_count !== 16'h0) begin n_fail++; $display("FAIL reset_counts got %h/%h want 0/0", jump_count, branch_count); end
    idle_inputs();
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc [5];
    exp_pc[0] = 32'h0; exp_pc[1] = 32'h4; exp_pc[2] = 32'h8; exp_pc[3] = 32'hC; exp_pc[4] = 32'h10;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) step();
      n_checks++; if (pc !== exp_pc[i]) begin n_fail++; $display("FAIL seq_pc[%0d] got %h want %h", i, pc, exp_pc[i]); end
      n_checks++; if (fetch_valid !== (i != 0)) begin n_fail++; $display("FAIL seq_fetch_valid[%0d] got %0b want %0b", i, fetch_valid, (i != 0)); end
    end
  endtask

  task automatic test_jump();
    id_valid = 1'b1; id_is_jump = 1'b1; id_pc_plus4 = 32'h4000_0010; id_jumpinstr = 26'h0000100;
    #1;
    n_checks++; if (flush_ifid !== 1'b1) begin n_fail++; $display("FAIL jump_flush_ifid got %0b want 1", flush_ifid); end
    n_checks++; if (flush_idex !== 1'b0) begin n_fail++; $display("FAIL jump_flush_idex got %0b want 0", flush_idex); end
    step();
    idle_inputs();
    n_checks++; if (pc !== 32'h4000_0400) begin n_fail++; $display("FAIL jump_pc got %h want 40000400", pc); end
    n_checks++; if (jump_count !== 16'd1) begin n_fail++; $display("FAIL jump_count got %0d want 1", jump_count); end
  endtask

  task automatic test_branch_jump();
    id_valid = 1'b1; id_is_jump = 1'b1; id_pc_plus4 = 32'h4000_0404; id_jumpinstr = 26'h0000200;
    ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0200;
    #1;
    n_checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin n_fail++; $display("FAIL bj_flushes got %0b%0b want 11", flush_ifid, flush_idex); end
    step();
    idle_inputs();
    n_checks++; if (pc !== 32'h0000_0200) begin n_fail++; $display("FAIL bj_pc got %h want 00000200", pc); end
    n_checks++; if (branch_count !== 16'd1) begin n_fail++; $display("FAIL bj_branch_count got %0d want 1", branch_count); end
    n_checks++; if (jump_count !== 16'd1) begin n_fail++; $display("FAIL bj_jump_count got %0d want 1", jump_count); end
  endtask

  task automatic test_imem_hold();
    imem_ready = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0300;
    #1;
    n_checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b1) begin n_fail++; $display("FAIL hold_flushes got %0b%0b want 11", flush_ifid, flush_idex); end
    for (int i = 0; i < 3; i++) begin
      step();
      ex_branch_taken = 1'b0;
      imem_ready = (i == 2);
      #1;
      n_checks++; if (pc !== 32'h0000_0200) begin n_fail++; $display("FAIL hold_pc[%0d] got %h want 00000200", i, pc); end
      n_checks++; if (fetch_valid !== 1'b0) begin n_fail++; $display("FAIL hold_fetch_valid[%0d] got %0b want 0", i, fetch_valid); end
      n_checks++; if (flush_ifid !== 1'b0 || flush_idex !== 1'b0) begin n_fail++; $display("FAIL hold_repeat_flush[%0d] got %0b%0b want 00", i, flush_ifid, flush_idex); end
    end
    step();
    n_checks++; if (pc !== 32'h0000_0300) begin n_fail++; $display("FAIL hold_release_pc got %h want 00000300", pc); end
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL hold_release_fetch_valid got %0b want 1", fetch_valid); end
    n_checks++; if (branch_count !== 16'd2) begin n_fail++; $display("FAIL hold_branch_count got %0d want 2", branch_count); end
  endtask

  task automatic test_stall_jump();
    stall = 1'b1; id_valid = 1'b1; id_is_jump = 1'b1; id_pc_plus4 = 32'h0000_0304; id_jumpinstr = 26'h0000040;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL stall_flush[%0d] got %0b want 0", i, flush_ifid); end
      step();
      n_checks++; if (pc !== 32'h0000_0300 || jump_count !== 16'd1) begin n_fail++; $display("FAIL stall_frozen[%0d] got pc=%h cnt=%0d want pc=00000300 cnt=1", i, pc, jump_count); end
    end
    stall = 1'b0;
    #1;
    n_checks++; if (flush_ifid !== 1'b1 || flush_idex !== 1'b0) begin n_fail++; $display("FAIL stall_release_flush got %0b%0b want 10", flush_ifid, flush_idex); end
    step();
    idle_inputs();
    #1;
    n_checks++; if (pc !== 32'h0000_0100) begin n_fail++; $display("FAIL stall_release_pc got %h want 00000100", pc); end
    n_checks++; if (jump_count !== 16'd2) begin n_fail++; $display("FAIL stall_jump_count got %0d want 2", jump_count); end
    n_checks++; if (flush_ifid !== 1'b0) begin n_fail++; $display("FAIL stall_single_pulse got %0b want 0", flush_ifid); end
  endtask

  task automatic test_wrap();
    id_valid = 1'b1; id_is_jump = 1'b1; id_pc_plus4 = 32'hF000_0000; id_jumpinstr = 26'h3FF_FFFF;
    step();
    idle_inputs();
    n_checks++; if (pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_target got %h want fffffffc", pc); end
    step();
    n_checks++; if (pc !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_pc got %h want 00000000", pc); end
  endtask

  task automatic test_reset_in_hold();
    imem_ready = 1'b0; ex_branch_taken = 1'b1; ex_branch_target = 32'h0000_0500;
    step();
    ex_branch_taken = 1'b0;
    n_checks++; if (fetch_valid !== 1'b0 || pc !== 32'h0) begin n_fail++; $display("FAIL rsthold_enter got pc=%h fv=%0b want pc=00000000 fv=0", pc, fetch_valid); end
    rst = 1'b1;
    step();
    rst = 1'b0; imem_ready = 1'b1;
    n_checks++; if (pc !== 32'h0 || jump_count !== 16'h0 || branch_count !== 16'h0) begin n_fail++; $display("FAIL rsthold_reset got pc=%h j=%0d b=%0d want 0/0/0", pc, jump_count, branch_count); end
    step();
    n_checks++; if (pc !== 32'h0000_0004) begin n_fail++; $display("FAIL rsthold_discard got %h want 00000004", pc); end
    n_checks++; if (fetch_valid !== 1'b1) begin n_fail++; $display("FAIL rsthold_fetch_valid got %0b want 1", fetch_valid); end
  endtask

  task automatic test_back_to_back_saturation();
    id_valid = 1'b1; id_is_jump = 1'b1; id_pc_plus4 = 32'h1000_0000;
    for (int i = 1; i <= 4; i++) begin
      id_jumpinstr = 26'(i * 16);
      step();
      n_checks++; if (pc !== (32'h1000_0000 | 32'(i * 64))) begin n_fail++; $display("FAIL b2b_pc[%0d] got %h want %h", i, pc, (32'h1000_0000 | 32'(i * 64))); end
      n_checks++; if (jump_count !== 16'(i)) begin n_fail++; $display("FAIL b2b_jump_count[%0d] got %0d want %0d", i, jump_count, i); end
      n_checks++; if (s_jump_count !== ((i < 3) ? 2'(i) : 2'd3)) begin n_fail++; $display("FAIL sat_jump_count[%0d] got %0d want %0d", i, s_jump_count, ((i < 3) ? i : 3)); end
    end
    idle_inputs();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_sequential();
    test_jump();
    test_branch_jump();
    test_imem_hold();
    test_stall_jump();
    test_wrap();
    test_reset_in_hold();
    test_back_to_back_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
